// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_GAP    = 2'd3
  } sched_state_t;

  localparam int          FRAME_COUNT_W      = 16;
  localparam logic [23:0] TIMEOUT_CYCLES_DEF = 24'hFFFFFF;

endpackage

// File: rtl/led_period_timer.sv
// Clearable saturating cycle counter with a compare-greater-or-equal flag.
// Clearing loads 1 so the clearing cycle itself is counted as elapsed.
module led_period_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         ge
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (clr)              cnt <= W'(1);
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

  assign ge = (cnt >= limit);

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame sequencer for the led_bank array: launch, wait-for-idle, period pacing,
// buffer swap between frames. LED_SCHED_TIMEOUT_EN enables the stuck-bank timeout.
module led_frame_scheduler import led_pkg::*; #(
  parameter int                  BANKS          = 4,
  parameter int                  PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] TIMEOUT_CYCLES = PERIOD_W'(TIMEOUT_CYCLES_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [PERIOD_W-1:0]      period,
  input  logic                     swap_req,
  input  logic                     err_clear,
  input  logic [BANKS-1:0]         bank_idle,
  output logic                     bank_go,
  output logic                     buf_sel,
  output logic                     swap_pending,
  output logic                     busy,
  output logic                     frame_done,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic                     timeout_err
);

  sched_state_t state;
  logic         launch;
  logic         per_ge;
  logic         to_hit;

  // Launch decode feeds both the FSM and the counter clears, so both see the same edge.
  always_comb begin
    launch = 1'b0;
    case (state)
      S_IDLE:  launch = start | (continuous & ~timeout_err);
      S_GAP:   launch = continuous & ~timeout_err & per_ge;
      default: launch = 1'b0;
    endcase
  end

  led_period_timer #(.W(PERIOD_W)) u_per (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (1'b1),
    .limit (period),
    .ge    (per_ge)
  );

`ifdef LED_SCHED_TIMEOUT_EN
  logic run_active;
  logic to_ge;

  assign run_active = (state == S_LAUNCH) || (state == S_RUN);

  led_period_timer #(.W(PERIOD_W)) u_to (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .en    (run_active),
    .limit (TIMEOUT_CYCLES),
    .ge    (to_ge)
  );

  assign to_hit = to_ge & run_active;
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bank_go      <= 1'b0;
      buf_sel      <= 1'b0;
      swap_pending <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (to_hit)         timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;

      if (launch) begin
        state   <= S_LAUNCH;
        bank_go <= 1'b1;
        busy    <= 1'b1;
        if (swap_pending) buf_sel <= ~buf_sel;
        // a request landing on this edge belongs to the next frame
        swap_pending <= swap_req;
      end else begin
        if (swap_req) swap_pending <= 1'b1;
        case (state)
          S_LAUNCH: begin
            if (to_hit) begin
              state   <= S_IDLE;
              bank_go <= 1'b0;
              busy    <= 1'b0;
            end else if (bank_idle == '0) begin
              state   <= S_RUN;
              bank_go <= 1'b0;
            end
          end
          S_RUN: begin
            if (&bank_idle) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
              if (continuous && !timeout_err) begin
                state <= S_GAP;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else if (to_hit) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_GAP: begin
            if (!continuous || timeout_err) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Frame sequencer between the memory-mapped control registers and the `led_bank` array. Turns software start/continuous requests into a handshaked `go` to all banks, waits for every bank to finish, and paces refreshes to a programmable frame period. Owns the double-buffer select so the strip memory swaps only between frames, and flags banks that never finish.

## Interface
- `BANKS`, 4, number of `led_bank` instances sequenced together
- `PERIOD_W`, 24, width of frame-period and timeout counters
- `TIMEOUT_CYCLES`, 24'hFFFFFF, max cycles from launch to all-idle before error
- `clk` in 1: bank clock domain; the only clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle pulse, request a single frame
- `continuous` in 1: level; while high, frames repeat every `period` cycles
- `period` in `PERIOD_W`: launch-to-launch spacing in continuous mode
- `swap_req` in 1: one-cycle pulse; back buffer is complete
- `err_clear` in 1: one-cycle pulse; clears `timeout_err`
- `bank_idle` in `BANKS`: idle flags from the banks
- `bank_go` out 1: go level to all banks
- `buf_sel` out 1: buffer the banks read (0/1)
- `swap_pending` out 1: swap requested, not yet applied
- `busy` out 1: high in any state except IDLE
- `frame_done` out 1: one-cycle pulse when a frame completes normally
- `frame_count` out 16: completed frames, wraps 16'hFFFF→0
- `timeout_err` out 1: sticky timeout flag

## Operation
- Reset values: state IDLE, all outputs 0, counters 0.
- States: IDLE, LAUNCH, RUN, GAP.
- IDLE: on `start`, or `continuous` high with `timeout_err` low, go to LAUNCH. `start` is ignored outside IDLE.
- Entering LAUNCH:
  - If `swap_pending` is set, toggle `buf_sel` and clear `swap_pending` on that edge.
  - Clear the period and timeout counters.
- LAUNCH: hold `bank_go`=1 until `bank_idle`==0 (all banks busy), then go to RUN with `bank_go`=0.
- RUN: when `&bank_idle`, pulse `frame_done`, increment `frame_count`, then go to GAP if `continuous`, else IDLE.
- GAP: when the period counter is ≥ `period`, go to LAUNCH. If `continuous` drops, go to IDLE. If `period` is shorter than the frame length, the next launch is on the cycle after RUN exits (back-to-back).
- Period counter: runs from LAUNCH entry and saturates at all-ones.
- `swap_req`:
  - Sets `swap_pending` at any time.
  - If it coincides with the LAUNCH-entry edge, it is applied at the next frame, not the current one.
  - A repeated request while pending has no additional effect.
- Timeout counter: runs in LAUNCH and RUN. On reaching `TIMEOUT_CYCLES`:
  - set `timeout_err`, drop `bank_go`, go to IDLE;
  - no `frame_done`, `frame_count` unchanged.
- While `timeout_err` is set, auto-launch is blocked; `start` still launches.
- `err_clear` coincident with a new timeout: set wins.

## Timing
- `start` at edge N → LAUNCH and `bank_go`=1 at N+1.
- `bank_go` falls the cycle after `bank_idle`==0 is sampled.
- `frame_done` and `frame_count` update the cycle after `&bank_idle` is sampled in RUN.
- `buf_sel` changes only on LAUNCH entry, so it is stable for the whole frame.
- All outputs are registered; no combinational input→output paths.

## Configuration
- `LED_SCHED_TIMEOUT_EN` defined: timeout counter and `timeout_err` behave as above.
- Undefined: no timeout logic, `timeout_err` tied 0, `err_clear` ignored, LAUNCH and RUN wait indefinitely.

## Structure
- Shared package `led_pkg`: state encoding enum; `FRAME_COUNT_W`=16; default `TIMEOUT_CYCLES`.
- One sub-module, `led_period_timer`: a clearable saturating counter with compare-≥ output, instanced for the period and timeout counters.
- The FSM and buffer-select logic stay in the top of the block.

## Test plan
- Single frame: reset, `start`, banks drop idle 2 cycles later and return after 100 → `bank_go` high 3 cycles, one `frame_done`, `frame_count`=1, back in IDLE.
- Continuous: `period`=500, frame 100 cycles → launches exactly 500 cycles apart. With `period`=10 → relaunch on the cycle after `frame_done`.
- Swap mid-frame: `swap_req` during RUN → `swap_pending`=1 until next launch, then `buf_sel` toggles 0→1. `swap_req` on the LAUNCH-entry edge → applied one frame later.
- Timeout (macro on, `TIMEOUT_CYCLES`=64): one bank stays busy → `timeout_err` at cycle 64, `bank_go`=0, no auto-relaunch. `err_clear` → continuous resumes.
- Reset mid-RUN: assert `reset` → all outputs 0 immediately (asynchronous). After release, no `frame_done` until a new `start`.
- Macro off: stuck bank → stays in RUN, `timeout_err`=0 indefinitely.
